// File: rtl/serial_frame_tx.sv
// rtl/serial_frame_tx.sv - serial frame transmitter: SOP, CMD(8), ADDR(24), DATA(32), optional PAR, GAP
// Optional even-parity bit after DATA: define SERIAL_FRAME_TX_PARITY_EN.
module serial_frame_tx #(
   parameter int CLKS_PER_BIT = 1,
   parameter int IDLE_GAP     = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  cmd,
   input  logic [23:0] addr,
   input  logic [31:0] data,
   output logic        tx,
   output logic        busy,
   output logic        done
);

   localparam logic [7:0] BIT_RELOAD = 8'(CLKS_PER_BIT - 1);
   localparam logic [3:0] GAP_RELOAD = 4'(IDLE_GAP - 1);

`ifdef SERIAL_FRAME_TX_PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_SOP, S_CMD, S_ADDR, S_DATA, S_PAR, S_GAP} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_SOP, S_CMD, S_ADDR, S_DATA, S_GAP} state_t;
`endif

   state_t      state_q, state_d;
   logic [7:0]  bit_cnt_q, bit_cnt_d;
   logic [6:0]  idx_q, idx_d;
   logic [3:0]  gap_cnt_q, gap_cnt_d;
   logic [63:0] shreg_q, shreg_d;
   logic        tx_q, tx_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        ready_q, ready_d;
   logic        bit_end;
   logic        last_bit;
`ifdef SERIAL_FRAME_TX_PARITY_EN
   logic        parity_q, parity_d;
`endif

   // Next-state logic: every output is computed one cycle ahead so the registers drive the pins.
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      idx_d     = idx_q;
      gap_cnt_d = gap_cnt_q;
      shreg_d   = shreg_q;
      tx_d      = tx_q;
      busy_d    = busy_q;
      ready_d   = ready_q;
`ifdef SERIAL_FRAME_TX_PARITY_EN
      parity_d  = parity_q;
`endif
      bit_end   = (bit_cnt_q == 8'd0);

      case (state_q)
         S_IDLE: begin
            tx_d   = 1'b1;
            busy_d = 1'b0;
            if (in_valid && ready_q) begin
               shreg_d   = {cmd, addr, data};
`ifdef SERIAL_FRAME_TX_PARITY_EN
               parity_d  = ^{cmd, addr, data};
`endif
               state_d   = S_SOP;
               tx_d      = 1'b0;
               busy_d    = 1'b1;
               ready_d   = 1'b0;
               bit_cnt_d = BIT_RELOAD;
               idx_d     = 7'd0;
            end else begin
               // Also raises in_ready on the first cycle out of reset.
               ready_d = 1'b1;
            end
         end
         default: begin
            if (!bit_end) begin
               bit_cnt_d = bit_cnt_q - 8'd1;
            end else begin
               bit_cnt_d = BIT_RELOAD;
               case (state_q)
                  S_SOP: begin
                     state_d = S_CMD;
                     idx_d   = 7'd0;
                     tx_d    = shreg_q[63];
                     shreg_d = {shreg_q[62:0], 1'b0};
                  end
                  S_CMD, S_ADDR, S_DATA: begin
                     if (idx_q == 7'd63) begin
`ifdef SERIAL_FRAME_TX_PARITY_EN
                        state_d = S_PAR;
                        tx_d    = parity_q;
`else
                        state_d   = S_GAP;
                        tx_d      = 1'b1;
                        gap_cnt_d = GAP_RELOAD;
`endif
                     end else begin
                        idx_d   = idx_q + 7'd1;
                        tx_d    = shreg_q[63];
                        shreg_d = {shreg_q[62:0], 1'b0};
                        if (idx_q == 7'd7) begin
                           state_d = S_ADDR;
                        end else if (idx_q == 7'd31) begin
                           state_d = S_DATA;
                        end
                     end
                  end
`ifdef SERIAL_FRAME_TX_PARITY_EN
                  S_PAR: begin
                     state_d   = S_GAP;
                     tx_d      = 1'b1;
                     gap_cnt_d = GAP_RELOAD;
                  end
`endif
                  S_GAP: begin
                     if (gap_cnt_q == 4'd0) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        ready_d = 1'b1;
                     end else begin
                        gap_cnt_d = gap_cnt_q - 4'd1;
                     end
                  end
                  default: state_d = S_IDLE;
               endcase
            end
         end
      endcase

      // done marks the final cycle of the final frame bit.
`ifdef SERIAL_FRAME_TX_PARITY_EN
      last_bit = (state_d == S_PAR);
`else
      last_bit = (state_d == S_DATA) && (idx_d == 7'd63);
`endif
      done_d = last_bit && (bit_cnt_d == 8'd0);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         bit_cnt_q <= 8'd0;
         idx_q     <= 7'd0;
         gap_cnt_q <= 4'd0;
         shreg_q   <= 64'd0;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         ready_q   <= 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
         parity_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         idx_q     <= idx_d;
         gap_cnt_q <= gap_cnt_d;
         shreg_q   <= shreg_d;
         tx_q      <= tx_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         ready_q   <= ready_d;
`ifdef SERIAL_FRAME_TX_PARITY_EN
         parity_q  <= parity_d;
`endif
      end
   end

   assign tx       = tx_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign in_ready = ready_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// tb/tb_serial_frame_tx.sv - self-checking bench for serial_frame_tx (1 and 4 clocks per bit)
`timescale 1ns/1ps
module tb_serial_frame_tx;

   localparam int CPB0 = 1;
   localparam int GAP0 = 2;
   localparam int CPB1 = 4;
   localparam int GAP1 = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]  rst;
   logic [1:0]  in_valid;
   logic [1:0]  in_ready;
   logic [1:0]  tx;
   logic [1:0]  busy;
   logic [1:0]  done;
   logic [7:0]  cmd  [2];
   logic [23:0] addr [2];
   logic [31:0] data [2];

   int passed = 0;
   int total  = 0;
   int failed = 0;

   serial_frame_tx #(.CLKS_PER_BIT(CPB0), .IDLE_GAP(GAP0)) u_dut0 (
      .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .cmd(cmd[0]), .addr(addr[0]), .data(data[0]),
      .tx(tx[0]), .busy(busy[0]), .done(done[0])
   );

   serial_frame_tx #(.CLKS_PER_BIT(CPB1), .IDLE_GAP(GAP1)) u_dut1 (
      .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .cmd(cmd[1]), .addr(addr[1]), .data(data[1]),
      .tx(tx[1]), .busy(busy[1]), .done(done[1])
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] rand64();
      return {$urandom, $urandom};
   endfunction

   function automatic logic [3:0] pins(input int u);
      return {tx[u], busy[u], done[u], in_ready[u]};
   endfunction

   // Sends word w on unit u starting in an IDLE cycle (at a negedge), checks every cycle of the
   // frame and gap against a bit list built from the frame rules, then checks the IDLE cycle.
   task automatic run_frame(input int u, input logic [63:0] w, input bit keep_valid,
                            input bit chain, input logic [63:0] next_w, input int abort_at,
                            input string tag);
      bit bits[$];
      int cpb, gap, fl, span, ndone;
      logic [3:0] exp;
      cpb = (u == 0) ? CPB0 : CPB1;
      gap = (u == 0) ? GAP0 : GAP1;
      bits.push_back(1'b0);
      for (int i = 63; i >= 0; i--) bits.push_back(w[i]);
`ifdef SERIAL_FRAME_TX_PARITY_EN
      bits.push_back(^w);
`endif
      fl    = bits.size();
      span  = (fl + gap) * cpb;
      ndone = 0;
      check($sformatf("%s:ready_at_start", tag), 64'(in_ready[u]), 64'd1);
      {cmd[u], addr[u], data[u]} = w;
      in_valid[u] = 1'b1;
      for (int k = 1; k <= span; k++) begin
         @(negedge clk);
         if (k <= fl * cpb) exp = {bits[(k - 1) / cpb], 1'b1, logic'(k == fl * cpb), 1'b0};
         else               exp = 4'b1100;
         check($sformatf("%s:cycle%0d {tx,busy,done,ready}", tag, k), 64'(pins(u)), 64'(exp));
         ndone += int'(done[u]);
         if (k == abort_at) begin
            rst[u] = 1'b1;
            in_valid[u] = 1'b0;
            @(negedge clk);
            check($sformatf("%s:in_reset", tag), 64'(pins(u)), 64'(4'b1000));
            rst[u] = 1'b0;
            @(negedge clk);
            check($sformatf("%s:after_reset", tag), 64'(pins(u)), 64'(4'b1001));
            return;
         end
         cmd[u]  = 8'($urandom);
         addr[u] = 24'($urandom);
         data[u] = $urandom;
         in_valid[u] = keep_valid ? 1'b1 : 1'($urandom_range(0, 1));
         if (k == span) begin
            in_valid[u] = chain;
            if (chain) {cmd[u], addr[u], data[u]} = next_w;
         end
      end
      check($sformatf("%s:done_count", tag), 64'(ndone), 64'd1);
      @(negedge clk);
      check($sformatf("%s:idle_cycle", tag), 64'(pins(u)), 64'(4'b1001));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] wa, wb;
      rst      = 2'b11;
      in_valid = 2'b00;
      for (int u = 0; u < 2; u++) begin
         cmd[u] = 8'd0; addr[u] = 24'd0; data[u] = 32'd0;
      end
      repeat (3) @(negedge clk);
      check("reset_u0", 64'(pins(0)), 64'(4'b1000));
      check("reset_u1", 64'(pins(1)), 64'(4'b1000));
      rst = 2'b00;
      @(negedge clk);
      check("first_idle_u0", 64'(pins(0)), 64'(4'b1001));
      check("first_idle_u1", 64'(pins(1)), 64'(4'b1001));

      run_frame(0, {8'hA5, 24'h123456, 32'hDEADBEEF}, 1'b0, 1'b0, 64'd0, -1, "vec_a5");
      for (int i = 0; i < 3; i++)
         run_frame(0, rand64(), 1'($urandom_range(0, 1)), 1'b0, 64'd0, -1, "rand_u0");

      wa = rand64();
      wb = rand64();
      run_frame(0, wa, 1'b1, 1'b1, wb, -1, "b2b_first");
      run_frame(0, wb, 1'b1, 1'b0, 64'd0, -1, "b2b_second");

      run_frame(0, rand64(), 1'b0, 1'b0, 64'd0, 30, "abort_addr20");
      run_frame(0, rand64(), 1'b0, 1'b0, 64'd0, -1, "post_abort");

      run_frame(1, {8'h01, 24'h0, 32'h0}, 1'b0, 1'b0, 64'd0, -1, "cpb4_cmd01");
      run_frame(1, {8'h01, 24'h0, 32'h1}, 1'b0, 1'b0, 64'd0, -1, "cpb4_data1");
      wa = rand64();
      run_frame(1, rand64(), 1'b1, 1'b1, wa, -1, "cpb4_b2b_first");
      run_frame(1, wa, 1'($urandom_range(0, 1)), 1'b0, 64'd0, -1, "cpb4_b2b_second");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
